// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared defaults and read-mode type for the sync_fifo slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

    localparam int c_DEF_DWIDTH             = 8;
    localparam int c_DEF_AWIDTH             = 4;
    localparam int c_DEF_SHOWAHEAD          = 1;
    localparam int c_DEF_ALMOST_FULL_VALUE  = 12;
    localparam int c_DEF_ALMOST_EMPTY_VALUE = 2;
    localparam int c_DEF_REGISTER_OUTPUT    = 0;

    typedef enum logic {
        RD_NORMAL    = 1'b0,
        RD_SHOWAHEAD = 1'b1
    } rd_mode_e;

    function automatic rd_mode_e rd_mode_from_int(input int showahead);
        return (showahead != 0) ? RD_SHOWAHEAD : RD_NORMAL;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module      : sync_fifo_mem
// Description : 2**AWIDTH x DWIDTH simple dual-port array, one write port and
//               one read port selectable between async and registered data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DWIDTH = c_DEF_DWIDTH,
    parameter int AWIDTH = c_DEF_AWIDTH
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              wr_en_i,
    input  logic [AWIDTH-1:0] wr_addr_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [AWIDTH-1:0] rd_addr_i,
    input  logic              rd_async_i,
    output logic [DWIDTH-1:0] rd_data_o
);

    logic [DWIDTH-1:0] mem_q [2**AWIDTH];
    logic [DWIDTH-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Captures the popped word; it is the normal-mode output and the value
    // held by show-ahead mode once the FIFO runs empty.
    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            rd_q <= '0;
        end else if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_async_i ? mem_q[rd_addr_i] : rd_q;

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with show-ahead/normal read, optional output
//               register and registered occupancy flags. Optional SVA checks
//               are compiled in with SYNC_FIFO_ASSERTIONS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DWIDTH             = c_DEF_DWIDTH,
    parameter int AWIDTH             = c_DEF_AWIDTH,
    parameter int SHOWAHEAD          = c_DEF_SHOWAHEAD,
    parameter int ALMOST_FULL_VALUE  = c_DEF_ALMOST_FULL_VALUE,
    parameter int ALMOST_EMPTY_VALUE = c_DEF_ALMOST_EMPTY_VALUE,
    parameter int REGISTER_OUTPUT    = c_DEF_REGISTER_OUTPUT
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              almost_full_o,
    output logic              almost_empty_o
);

    localparam rd_mode_e          c_RD_MODE = rd_mode_from_int(SHOWAHEAD);
    localparam logic [AWIDTH:0]   c_DEPTH   = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]   c_AF_LVL  = (AWIDTH+1)'(ALMOST_FULL_VALUE);
    localparam logic [AWIDTH:0]   c_AE_LVL  = (AWIDTH+1)'(ALMOST_EMPTY_VALUE);
    localparam logic [AWIDTH-1:0] c_PTR_ONE = AWIDTH'(1);
    localparam logic [AWIDTH:0]   c_CNT_ONE = (AWIDTH+1)'(1);

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   count_q, count_d;
    logic              empty_q, full_q, afull_q, aempty_q;
    logic              w_wr_acc, w_rd_acc, w_rd_async;
    logic [DWIDTH-1:0] w_mem_q;

    assign w_wr_acc = wrreq_i && !full_q;
    assign w_rd_acc = rdreq_i && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + c_PTR_ONE;
        end
        if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
        end
        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Flags come from the post-edge count so they are valid the cycle after.
    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == c_DEPTH);
            afull_q  <= (count_d >= c_AF_LVL);
            aempty_q <= (count_d <  c_AE_LVL);
        end
    end

    assign w_rd_async = (c_RD_MODE == RD_SHOWAHEAD) && !empty_q;

    sync_fifo_mem #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_mem (
        .clk_i      (clk_i),
        .srst_i     (srst_i),
        .wr_en_i    (w_wr_acc),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  (data_i),
        .rd_en_i    (w_rd_acc),
        .rd_addr_i  (rd_ptr_q),
        .rd_async_i (w_rd_async),
        .rd_data_o  (w_mem_q)
    );

    generate
        if (REGISTER_OUTPUT != 0) begin : g_out_reg
            logic [DWIDTH-1:0] out_q;
            always_ff @(posedge clk_i or negedge srst_i) begin
                if (!srst_i) begin
                    out_q <= '0;
                end else begin
                    out_q <= w_mem_q;
                end
            end
            assign q_o = out_q;
        end else begin : g_out_comb
            assign q_o = w_mem_q;
        end
    endgenerate

    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign usedw_o        = count_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;

`ifdef SYNC_FIFO_ASSERTIONS_EN
    a_wr_while_full: assert property (@(posedge clk_i) disable iff (!srst_i)
        !(wrreq_i && full_o))
        else $warning("sync_fifo: write request while full ignored");

    a_rd_while_empty: assert property (@(posedge clk_i) disable iff (!srst_i)
        !(rdreq_i && empty_o))
        else $warning("sync_fifo: read request while empty ignored");

    a_usedw_ptrs: assert property (@(posedge clk_i) disable iff (!srst_i)
        (count_q[AWIDTH-1:0] == AWIDTH'(wr_ptr_q - rd_ptr_q)) && (count_q <= c_DEPTH))
        else $error("sync_fifo: usedw inconsistent with pointers");

    a_full_empty_excl: assert property (@(posedge clk_i) disable iff (!srst_i)
        !(full_o && empty_o))
        else $error("sync_fifo: full and empty both asserted");

    a_flags_known: assert property (@(posedge clk_i) disable iff (!srst_i)
        !$isunknown({empty_o, full_o, almost_full_o, almost_empty_o, usedw_o}))
        else $error("sync_fifo: unknown value on flags");
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo.sv
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench: show-ahead, normal and registered-normal
//               FIFOs driven in lockstep and compared to a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFV   = 12;
    localparam int AEV   = 2;

    logic          clk = 1'b0;
    logic          srst_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;

    // Index 0: show-ahead, 1: normal, 2: normal with output register.
    logic [DW-1:0] q_w     [3];
    logic          empty_w [3];
    logic          full_w  [3];
    logic [AW:0]   usedw_w [3];
    logic          af_w    [3];
    logic          ae_w    [3];

    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_last = '0;
    logic [DW-1:0] m_reg  = '0;
    int            n_checks = 0;
    int            n_err    = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(1), .ALMOST_FULL_VALUE(AFV),
                .ALMOST_EMPTY_VALUE(AEV), .REGISTER_OUTPUT(0)) dut_sa (
        .clk_i(clk), .srst_i(srst_n), .data_i(din), .wrreq_i(wr), .rdreq_i(rd),
        .q_o(q_w[0]), .empty_o(empty_w[0]), .full_o(full_w[0]), .usedw_o(usedw_w[0]),
        .almost_full_o(af_w[0]), .almost_empty_o(ae_w[0]));

    sync_fifo #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(0), .ALMOST_FULL_VALUE(AFV),
                .ALMOST_EMPTY_VALUE(AEV), .REGISTER_OUTPUT(0)) dut_nm (
        .clk_i(clk), .srst_i(srst_n), .data_i(din), .wrreq_i(wr), .rdreq_i(rd),
        .q_o(q_w[1]), .empty_o(empty_w[1]), .full_o(full_w[1]), .usedw_o(usedw_w[1]),
        .almost_full_o(af_w[1]), .almost_empty_o(ae_w[1]));

    sync_fifo #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(0), .ALMOST_FULL_VALUE(AFV),
                .ALMOST_EMPTY_VALUE(AEV), .REGISTER_OUTPUT(1)) dut_nr (
        .clk_i(clk), .srst_i(srst_n), .data_i(din), .wrreq_i(wr), .rdreq_i(rd),
        .q_o(q_w[2]), .empty_o(empty_w[2]), .full_o(full_w[2]), .usedw_o(usedw_w[2]),
        .almost_full_o(af_w[2]), .almost_empty_o(ae_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        int            sz;
        logic [DW-1:0] head;
        sz   = m_q.size();
        head = (sz > 0) ? m_q[0] : m_last;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s.d%0d.usedw", ph, i), 32'(usedw_w[i]), 32'(sz));
            chk($sformatf("%s.d%0d.empty", ph, i), 32'(empty_w[i]), 32'(sz == 0));
            chk($sformatf("%s.d%0d.full",  ph, i), 32'(full_w[i]),  32'(sz == DEPTH));
            chk($sformatf("%s.d%0d.afull", ph, i), 32'(af_w[i]),    32'(sz >= AFV));
            chk($sformatf("%s.d%0d.aempty", ph, i), 32'(ae_w[i]),   32'(sz < AEV));
        end
        chk($sformatf("%s.d0.q", ph), 32'(q_w[0]), 32'(head));
        chk($sformatf("%s.d1.q", ph), 32'(q_w[1]), 32'(m_last));
        chk($sformatf("%s.d2.q", ph), 32'(q_w[2]), 32'(m_reg));
    endtask

    // One clock: drive inputs, advance the model across the edge, then check.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string ph);
        bit wa, ra;
        wr  = w;
        rd  = r;
        din = d;
        wa  = w && (m_q.size() < DEPTH);
        ra  = r && (m_q.size() > 0);
        @(posedge clk);
        m_reg = m_last;
        if (ra) m_last = m_q.pop_front();
        if (wa) m_q.push_back(d);
        #1;
        check_all(ph);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last = '0;
        m_reg  = '0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        srst_n = 1'b1;

        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, DW'($urandom), "fill");
        step(1'b1, 1'b0, 8'hA5, "wr_full");
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, '0, "drain");

        for (int i = 0; i < 3; i++)  step(1'b1, 1'b0, DW'($urandom), "pre3");
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'($urandom), "rw_wrap");

        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 40, DW'($urandom), "rand_up");
        for (int i = 0; i < 300; i++)
            step($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 60, DW'($urandom), "rand_dn");

        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, '0, "empty_out");
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b0, DW'($urandom), "fill8");

        // Reset mid-cycle: outputs must clear without a clock edge.
        wr = 1'b0;
        rd = 1'b0;
        #2 srst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #2 srst_n = 1'b1;

        for (int i = 0; i < 40; i++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, DW'($urandom), "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parameterizable first-in first-out buffer for crossing rate mismatches between producer and consumer logic in the same clock domain. Depth is 2**AWIDTH words of DWIDTH bits. It supports show-ahead or normal read mode, an optional output register, and occupancy/almost flags. Module name: `sync_fifo`.

## Interface
- DWIDTH, 8: data word width.
- AWIDTH, 4: address width; depth = 2**AWIDTH.
- SHOWAHEAD, 1: 1 = head word presented on q_o before rdreq; 0 = normal (read-then-data) mode.
- ALMOST_FULL_VALUE, 12: almost_full threshold.
- ALMOST_EMPTY_VALUE, 2: almost_empty threshold.
- REGISTER_OUTPUT, 0: 1 = extra register stage on q_o.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- srst_i  in  1  reset; asynchronous, active-low.
- data_i  in  DWIDTH  write data.
- wrreq_i  in  1  write request.
- rdreq_i  in  1  read request/acknowledge.
- q_o  out  DWIDTH  read data.
- empty_o  out  1  no words stored.
- full_o  out  1  2**AWIDTH words stored.
- usedw_o  out  AWIDTH+1  words stored (0..2**AWIDTH).
- almost_full_o  out  1  usedw_o >= ALMOST_FULL_VALUE.
- almost_empty_o  out  1  usedw_o < ALMOST_EMPTY_VALUE.

## Operation
- Write accepted iff wrreq_i && !full_o; data_i stored at write pointer, pointer increments (wraps mod 2**AWIDTH).
- Read accepted iff rdreq_i && !empty_o; read pointer increments (wraps).
- Write when full: ignored, no state change. Read when empty: ignored; q_o holds last value.
- Simultaneous accepted read and write: usedw_o unchanged, both pointers advance.
- Full with rdreq and wrreq both high: only the read is accepted (the write is rejected because full_o is high).
- Empty with rdreq and wrreq both high: only the write is accepted.
- usedw_o, empty_o, full_o, almost flags are registered and derived from the post-edge count.
- SHOWAHEAD=1: q_o continuously shows the word at the read pointer while !empty_o; rdreq_i pops it.
- SHOWAHEAD=0: an accepted read loads the head word into q_o.
- Data order strictly preserved.

## Timing
- Reset (srst_i low, asynchronous): pointers 0, usedw_o=0, empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, q_o=0. Memory contents are not reset.
- Flags and usedw_o update on the edge that accepts the operation (visible the following cycle).
- SHOWAHEAD=1, REGISTER_OUTPUT=0: the first word written into an empty FIFO is valid on q_o in the same cycle empty_o deasserts. After a pop, the next word is valid the next cycle.
- SHOWAHEAD=0, REGISTER_OUTPUT=0: q_o valid 1 cycle after the accepting read edge.
- REGISTER_OUTPUT=1: add 1 cycle of q_o latency in both modes; flags are not delayed.
- Reset mid-operation: immediate return to the reset state; pending data is discarded.

## Configuration
- SYNC_FIFO_ASSERTIONS_EN defined: compile in SVA checks for wrreq_i while full_o, rdreq_i while empty_o (warnings), usedw_o == wr_ptr−rd_ptr consistency, full_o/empty_o never both high, and no X on flags after reset (errors).
- SYNC_FIFO_ASSERTIONS_EN not defined: no checks compiled; RTL behaviour is identical.

## Structure
- Package sync_fifo_pkg: default parameter constants and an enum for the read-mode selection (SHOWAHEAD/normal).
- Sub-module sync_fifo_mem: simple dual-port storage array (one write port, one read port) holding 2**AWIDTH x DWIDTH. The read port is asynchronous for show-ahead mode and registered for normal mode. sync_fifo holds the pointers, count, flags and output register.

## Test plan
- Reset, then 16 back-to-back writes, rdreq low: after write 1, empty_o=0. After write 2, almost_empty_o=0. After write 12, almost_full_o=1. After write 16, full_o=1 and usedw_o=16.
- From full, a 17th write: ignored, usedw_o stays 16. Reading back shows the original 16 words, unchanged and in order.
- Full, then rdreq held 30 cycles (SHOWAHEAD=1): q_o yields the 16 words in write order, one per cycle, and empty_o=1 after the 16th. Further reads are ignored and q_o holds.
- Write 3 words, then simultaneous wrreq/rdreq for 20 cycles: usedw_o stays 3 and data stays in order across pointer wrap-around.
- SHOWAHEAD=0 and REGISTER_OUTPUT=1 variants: read data appears 1 and 2 cycles after the accepting read edge respectively.
- Assert srst_i low while holding 8 words: empty_o=1 and usedw_o=0 immediately, without waiting for a clock edge.
